// File: rtl/network_pkg.sv
// Shared network definitions: flit type encodings, packer FSM states and
// HEAD flit field offsets.
// Optional feature macro: VNI_PACKER_CHECKSUM_EN (adds the S_CSUM state).
package network_pkg;

  localparam int unsigned TYPE_W  = 2;
  localparam int unsigned SEQ_W   = 8;
  localparam int unsigned DST_W   = 8;
  localparam int unsigned SEQ_LSB = 8;
  localparam int unsigned DST_LSB = 0;

  // Flit type carried in bits [DW-1:DW-2] of every flit.
  typedef enum logic [TYPE_W-1:0] {
    FLIT_IDLE = 2'b00,
    FLIT_HEAD = 2'b01,
    FLIT_BODY = 2'b10,
    FLIT_TAIL = 2'b11
  } flit_type_e;

`ifdef VNI_PACKER_CHECKSUM_EN
  typedef enum logic [1:0] {
    S_HEAD = 2'b00,
    S_BODY = 2'b01,
    S_CSUM = 2'b10
  } pkr_state_e;
`else
  typedef enum logic [1:0] {
    S_HEAD = 2'b00,
    S_BODY = 2'b01
  } pkr_state_e;
`endif

endpackage

// File: rtl/virtual_ni_packer.sv
// Frames the PE's raw flit stream into wormhole packets for the router local
// port: HEAD(seq, DST_ID), then PKT_LEN data flits, the last tagged TAIL.
// With VNI_PACKER_CHECKSUM_EN defined, all data flits are BODY and an extra
// TAIL flit carrying the payload sum closes each packet.
// Ports:
//   clk, rstn          clock, async active-low reset
//   in_data/valid/ready   PE side (input type bits ignored)
//   out_data/valid/ready  router side, single output register
module virtual_ni_packer
  import network_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned PKT_LEN = 4,
  parameter logic [7:0]  DST_ID  = 8'h00
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int unsigned PW       = DW - TYPE_W;
  localparam logic [7:0]  LAST_CNT = 8'(PKT_LEN - 1);

  pkr_state_e    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    seq_q, seq_d;
  logic [DW-1:0] out_data_d;
  logic          out_valid_d;
  logic          slot_free_c;
  logic [PW-1:0] head_pl_c;
  logic [PW-1:0] in_pl_c;
  logic          type_unused_c;
`ifdef VNI_PACKER_CHECKSUM_EN
  logic [PW-1:0] sum_q, sum_d;
`endif

  // Input type bits are overwritten by the framing and intentionally dropped.
  assign in_pl_c       = in_data[PW-1:0];
  assign type_unused_c = ^in_data[DW-1:PW];

  // Output register can take a new flit when empty or being drained this cycle.
  assign slot_free_c = !out_valid || out_ready;
  assign in_ready    = (state_q == S_BODY) && slot_free_c;

  // HEAD payload: seq and destination, everything else zero.
  always_comb begin
    head_pl_c                     = '0;
    head_pl_c[SEQ_LSB +: SEQ_W]   = seq_q;
    head_pl_c[DST_LSB +: DST_W]   = DST_ID;
  end

  // Next-state and output-register load logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seq_d       = seq_q;
    out_data_d  = out_data;
    out_valid_d = out_valid && !out_ready;
`ifdef VNI_PACKER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    unique case (state_q)
      S_HEAD: begin
        // HEAD only goes out once the PE has data, so no orphan heads.
        if (in_valid && slot_free_c) begin
          out_data_d  = {FLIT_HEAD, head_pl_c};
          out_valid_d = 1'b1;
          state_d     = S_BODY;
`ifdef VNI_PACKER_CHECKSUM_EN
          sum_d       = '0;
`endif
        end
      end
      S_BODY: begin
        if (in_valid && slot_free_c) begin
          out_valid_d = 1'b1;
`ifdef VNI_PACKER_CHECKSUM_EN
          sum_d       = sum_q + in_pl_c;
`endif
          if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
`ifdef VNI_PACKER_CHECKSUM_EN
            out_data_d = {FLIT_BODY, in_pl_c};
            state_d    = S_CSUM;
`else
            out_data_d = {FLIT_TAIL, in_pl_c};
            state_d    = S_HEAD;
            seq_d      = seq_q + 8'd1;
`endif
          end else begin
            cnt_d      = cnt_q + 8'd1;
            out_data_d = {FLIT_BODY, in_pl_c};
          end
        end
      end
`ifdef VNI_PACKER_CHECKSUM_EN
      S_CSUM: begin
        if (slot_free_c) begin
          out_data_d  = {FLIT_TAIL, sum_q};
          out_valid_d = 1'b1;
          state_d     = S_HEAD;
          seq_d       = seq_q + 8'd1;
        end
      end
`endif
      default: state_d = S_HEAD;
    endcase
  end

  // State, counters and output register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_HEAD;
      cnt_q     <= '0;
      seq_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
`ifdef VNI_PACKER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      seq_q     <= seq_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
`ifdef VNI_PACKER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

endmodule

// File: doc/virtual_ni_packer.md
# virtual_ni_packer

Packetizing stage directly downstream of a node's virtual PE. It takes the PE's raw flit stream, where the type field is ignored, and frames it into wormhole packets for the router local input port. Each packet is one HEAD flit carrying the destination and a sequence number, followed by PKT_LEN data flits, the last of which is tagged TAIL. It is used only in deadlock-verification networks, so it is purely structural and performs no payload computation beyond the optional checksum.

## Interface
- DW: from params.svh. Flit width; bits [DW-1:DW-2] are the flit type, bits [DW-3:0] are the payload. DW ≥ 18 is required.
- PKT_LEN, default 4: data flits per packet, legal range 1..255.
- DST_ID, default 8'h00: router destination ID placed in every HEAD flit.
- clk  input  1  the block's single clock.
- rstn  input  1  active-low asynchronous reset.
- in_data  input  DW  flit from the PE (the PE's cast or merge output); type bits are ignored.
- in_valid  input  1  in_data valid.
- in_ready  output  1  flit accepted when in_valid & in_ready at a clk rising edge.
- out_data  output  DW  framed flit to the router local port.
- out_valid  output  1  out_data valid.
- out_ready  input  1  router accepts when out_valid & out_ready at a clk rising edge.

## Operation
- The FSM has two states.
  - S_HEAD (reset state): emits a HEAD flit, with payload bits [15:8] = seq, bits [7:0] = DST_ID, and all other payload bits zero. The HEAD flit consumes no input. It is issued only when in_valid=1, so no orphan heads are produced. After issuing it the FSM goes to S_BODY.
  - S_BODY: each accepted input flit is forwarded with its payload unchanged and its type rewritten. The type is BODY for data flits 1..PKT_LEN-1 and TAIL for flit PKT_LEN. After the last flit the FSM returns to S_HEAD and seq increments.
- cnt counts data flits within a packet, in the range 0..PKT_LEN-1. It clears when the last flit of the packet is emitted.
- seq is an 8-bit counter that wraps 255→0.
- With PKT_LEN=1, each packet is HEAD then TAIL.
- The output stage is a single register. It loads when out_valid=0 or out_ready=1 ("slot free").
- in_ready = (state==S_BODY) & slot free. in_ready is combinational from out_ready and has no combinational path from in_valid.
- Simultaneous events: in the same cycle, the register can be drained by the router and refilled from the input.
- Reset asserted mid-packet:
  - The partial packet is dropped.
  - state resets to S_HEAD and cnt, seq and out_valid reset to 0.
  - The router must be reset together with this block.

## Timing
- Reset values: out_valid=0, out_data=0, in_ready=0.
- Latency: an input accepted at edge k is presented on out_data at edge k (registered, visible in cycle k+1).
- A HEAD flit appears one cycle after in_valid is sampled high in S_HEAD with the slot free.
- Throughput is 1 flit/cycle, so a packet occupies PKT_LEN+1 output cycles, or PKT_LEN+2 with the checksum enabled.
- While out_valid=1 and out_ready=0, out_data and out_valid are held stable and in_ready=0.
- out_valid never drops without a handshake.

## Configuration
- Macro: VNI_PACKER_CHECKSUM_EN.
- Defined:
  - All PKT_LEN data flits are tagged BODY.
  - A sum register accumulates data payloads modulo 2^(DW-2) and clears at each HEAD.
  - The FSM enters a third state, S_CSUM. In S_CSUM, in_ready=0, and the block emits one extra TAIL flit whose payload is the sum, then returns to S_HEAD.
- Undefined: S_CSUM and the sum register are absent, and the last data flit is tagged TAIL.

## Structure
- Shared package, network_pkg, contains:
  - flit-type encodings (HEAD/BODY/TAIL) consistent with params.svh;
  - the state enum;
  - HEAD field offsets (SEQ_LSB=8, DST_LSB=0).
- No sub-module: the FSM, counters and the output register stay inline (about 150–250 lines).

## Test plan
- Basic packet (DW=32, PKT_LEN=4, DST_ID=8'h23): inputs 1,2,3,4 with out_ready=1 → HEAD with payload 0x0023, then BODY 1, BODY 2, BODY 3, TAIL 4, on 5 consecutive cycles.
- Backpressure: drop out_ready for 3 cycles after the 2nd data flit → out_data held, in_ready=0, no loss or duplication, and 5 flits total.
- Sequence wrap: 257 back-to-back packets → HEAD seq fields 0..255, then 0.
- VNI_PACKER_CHECKSUM_EN with inputs 1,2,3,4 → HEAD, BODY 1..4, then TAIL with payload 10. With the macro off, flit 4 is TAIL and there is no sixth flit.
- Reset mid-packet: assert rstn after HEAD + 2 data flits → out_valid=0 immediately. After release, the next packet starts with HEAD seq=0.
- PKT_LEN=1 with a gapped in_valid (1 cycle on, 2 off) → each packet is exactly HEAD followed by TAIL, and no HEAD is emitted without a following input.
